trireg_keeper: RTL and testbench

Parametrised multi-channel charge-retention bus model: each channel resolves several tri-state drivers into an explicit 4-state value, then holds the last driven value while undriven. After a configurable number of undriven cycles, the held charge decays to a pull value. It sits between driver-side logic and consumers that need synthesizable trireg/tri0/tri1 semantics. It generalises a single fixed trireg net to CHANNELS × WIDTH bits, with a driver count, decay time and pull mode.

---
 rtl/trireg_keeper_pkg.sv | 25 ++
 rtl/trireg_keeper_chan.sv | 125 ++++++++++++
 rtl/trireg_keeper.sv | 43 ++++
 tb/tb_trireg_keeper.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/trireg_keeper_pkg.sv
// rtl/trireg_keeper_pkg.sv - shared types and pull-value helper for trireg_keeper
package trireg_keeper_pkg;

  typedef enum logic [1:0] {
    PULL_NONE = 2'd0,
    PULL_DOWN = 2'd1,
    PULL_UP   = 2'd2
  } pull_e;

  typedef enum logic [1:0] {
    ST_DRIVEN  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DECAYED = 2'd2
  } state_e;

  // Returns the per-bit {val, unk} pair; callers replicate it across WIDTH bits.
  function automatic logic [1:0] pull_val(pull_e p);
    case (p)
      PULL_DOWN: pull_val = 2'b00;
      PULL_UP:   pull_val = 2'b10;
      default:   pull_val = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/trireg_keeper_chan.sv
// rtl/trireg_keeper_chan.sv - one channel: driver resolution, hold/decay FSM, conflict flags
module trireg_keeper_chan
  import trireg_keeper_pkg::*;
#(
  parameter int    WIDTH   = 8,
  parameter int    DRIVERS = 2,
  parameter int    DECAY   = 15,
  parameter pull_e PULL    = PULL_NONE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DRIVERS-1:0]         drv_en,
  input  logic [DRIVERS*WIDTH-1:0]   drv_val,
  input  logic                       conf_clr,
  output logic [WIDTH-1:0]           bus_val,
  output logic [WIDTH-1:0]           bus_unk,
  output logic                       bus_held,
  output logic                       conflict,
  output logic                       conflict_sticky
);

  localparam int CW = (DECAY + 1 > 2) ? $clog2(DECAY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((DECAY > 0) ? DECAY - 1 : 0);
  localparam logic [1:0] PV = pull_val(PULL);
  localparam logic [WIDTH-1:0] PULL_V = {WIDTH{PV[1]}};
  localparam logic [WIDTH-1:0] PULL_U = {WIDTH{PV[0]}};

  state_e          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0] val_d, unk_d;
  logic            held_d, conf_d, sticky_d;

  logic [WIDTH-1:0] and_v, or_v;
  logic             any_en;

  // AND and OR across enabled drivers: equal bits agree, differing bits conflict.
  always_comb begin
    and_v = '1;
    or_v  = '0;
    for (int d = 0; d < DRIVERS; d++) begin
      if (drv_en[d]) begin
        and_v = and_v & drv_val[d*WIDTH +: WIDTH];
        or_v  = or_v  | drv_val[d*WIDTH +: WIDTH];
      end
    end
    any_en = |drv_en;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    val_d   = bus_val;
    unk_d   = bus_unk;
    held_d  = bus_held;
    conf_d  = 1'b0;
    if (any_en) begin
      state_d = ST_DRIVEN;
      cnt_d   = '0;
      val_d   = and_v;
      unk_d   = or_v & ~and_v;
      held_d  = 1'b0;
      conf_d  = |(or_v & ~and_v);
    end else begin
      case (state)
        ST_DRIVEN: begin
          if (DECAY == 0) begin
            state_d = ST_HOLD;
            held_d  = 1'b1;
          end else if (DECAY == 1) begin
            state_d = ST_DECAYED;
            val_d   = PULL_V;
            unk_d   = PULL_U;
            held_d  = 1'b0;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_INIT;
            held_d  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (DECAY != 0) begin
            if (cnt == CW'(1)) begin
              state_d = ST_DECAYED;
              cnt_d   = '0;
              val_d   = PULL_V;
              unk_d   = PULL_U;
              held_d  = 1'b0;
            end else begin
              cnt_d = cnt - CW'(1);
            end
          end
        end
        ST_DECAYED: state_d = ST_DECAYED;
        default: begin
          state_d = ST_DECAYED;
          val_d   = PULL_V;
          unk_d   = PULL_U;
          held_d  = 1'b0;
        end
      endcase
    end
    sticky_d = conf_d | (conflict_sticky & ~conf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_DECAYED;
      cnt             <= '0;
      bus_val         <= PULL_V;
      bus_unk         <= PULL_U;
      bus_held        <= 1'b0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      bus_val         <= val_d;
      bus_unk         <= unk_d;
      bus_held        <= held_d;
      conflict        <= conf_d;
      conflict_sticky <= sticky_d;
    end
  end

endmodule

// File: rtl/trireg_keeper.sv
// rtl/trireg_keeper.sv - multi-channel charge-retention bus; slices flat buses per channel
module trireg_keeper
  import trireg_keeper_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    CHANNELS = 4,
  parameter int    DRIVERS  = 2,
  parameter int    DECAY    = 15,
  parameter pull_e PULL     = PULL_NONE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*DRIVERS-1:0]         drv_en,
  input  logic [CHANNELS*DRIVERS*WIDTH-1:0]   drv_val,
  input  logic [CHANNELS-1:0]                 conf_clr,
  output logic [CHANNELS*WIDTH-1:0]           bus_val,
  output logic [CHANNELS*WIDTH-1:0]           bus_unk,
  output logic [CHANNELS-1:0]                 bus_held,
  output logic [CHANNELS-1:0]                 conflict,
  output logic [CHANNELS-1:0]                 conflict_sticky
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    trireg_keeper_chan #(
      .WIDTH   (WIDTH),
      .DRIVERS (DRIVERS),
      .DECAY   (DECAY),
      .PULL    (PULL)
    ) u_chan (
      .clk             (clk),
      .rst             (rst),
      .drv_en          (drv_en[c*DRIVERS +: DRIVERS]),
      .drv_val         (drv_val[c*DRIVERS*WIDTH +: DRIVERS*WIDTH]),
      .conf_clr        (conf_clr[c]),
      .bus_val         (bus_val[c*WIDTH +: WIDTH]),
      .bus_unk         (bus_unk[c*WIDTH +: WIDTH]),
      .bus_held        (bus_held[c]),
      .conflict        (conflict[c]),
      .conflict_sticky (conflict_sticky[c])
    );
  end

endmodule

// File: tb/tb_trireg_keeper.sv
// tb/tb_trireg_keeper.sv - directed self-checking bench for trireg_keeper
module tb_trireg_keeper;
  import trireg_keeper_pkg::*;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [7:0]  en0;
  logic [31:0] val0;
  logic [3:0]  clr0;
  logic [15:0] bv0, bu0;
  logic [3:0]  held0, cf0, cs0;
  logic [1:0]  en1;
  logic [7:0]  val1;
  logic [0:0]  clr1;
  logic [3:0]  bv1, bu1;
  logic [0:0]  held1, cf1, cs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trireg_keeper #(.WIDTH(4), .CHANNELS(4), .DRIVERS(2), .DECAY(3), .PULL(PULL_NONE)) dut0 (
    .clk(clk), .rst(rst0), .drv_en(en0), .drv_val(val0), .conf_clr(clr0),
    .bus_val(bv0), .bus_unk(bu0), .bus_held(held0), .conflict(cf0), .conflict_sticky(cs0));

  trireg_keeper #(.WIDTH(4), .CHANNELS(1), .DRIVERS(2), .DECAY(0), .PULL(PULL_UP)) dut1 (
    .clk(clk), .rst(rst1), .drv_en(en1), .drv_val(val1), .conf_clr(clr1),
    .bus_val(bv1), .bus_unk(bu1), .bus_held(held1), .conflict(cf1), .conflict_sticky(cs1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int d, input logic e, input logic [3:0] v);
    en0[ch*2+d] = e;
    val0[(ch*2+d)*4 +: 4] = v;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    checks++; if (bu0 !== 16'hFFFF) begin errors++; $display("FAIL reset_unk got %h exp ffff", bu0); end
    checks++; if (bv0 !== 16'h0000) begin errors++; $display("FAIL reset_val got %h exp 0000", bv0); end
    checks++; if ({held0, cf0, cs0} !== 12'h000) begin errors++; $display("FAIL reset_flags got %h exp 000", {held0, cf0, cs0}); end
    checks++; if ({bv1, bu1} !== 8'hF0) begin errors++; $display("FAIL reset_pullup got %h exp f0", {bv1, bu1}); end
  endtask

  task automatic test_hold_decay();
    drive(0, 0, 1'b1, 4'hA);
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b1010_0000_0) begin errors++; $display("FAIL drive_a got %b exp 101000000", {bv0[3:0], bu0[3:0], held0[0]}); end
    drive(0, 0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b1010_0000_1) begin errors++; $display("FAIL hold_a%0d got %b exp 101000001", i, {bv0[3:0], bu0[3:0], held0[0]}); end
    end
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b0000_1111_0) begin errors++; $display("FAIL decay_a got %b exp 000011110", {bv0[3:0], bu0[3:0], held0[0]}); end
  endtask

  task automatic test_conflict();
    drive(0, 0, 1'b1, 4'hC);
    drive(0, 1, 1'b1, 4'hA);
    tick();
    checks++; if ({bv0[3:0], bu0[3:0]} !== 8'b1000_0110) begin errors++; $display("FAIL conf_bus got %b exp 10000110", {bv0[3:0], bu0[3:0]}); end
    checks++; if ({cf0, cs0} !== 8'b0001_0001) begin errors++; $display("FAIL conf_pulse got %b exp 00010001", {cf0, cs0}); end
    drive(0, 0, 1'b0, 4'h0);
    drive(0, 1, 1'b0, 4'h0);
    tick();
    checks++; if ({cf0[0], cs0[0]} !== 2'b01) begin errors++; $display("FAIL conf_after got %b exp 01", {cf0[0], cs0[0]}); end
    clr0[0] = 1'b1;
    tick();
    checks++; if (cs0[0] !== 1'b0) begin errors++; $display("FAIL conf_clr got %b exp 0", cs0[0]); end
    drive(0, 0, 1'b1, 4'hC);
    drive(0, 1, 1'b1, 4'hA);
    tick();
    checks++; if ({cf0[0], cs0[0]} !== 2'b11) begin errors++; $display("FAIL conf_set_wins got %b exp 11", {cf0[0], cs0[0]}); end
    clr0[0] = 1'b0;
    drive(0, 0, 1'b0, 4'h0);
    drive(0, 1, 1'b0, 4'h0);
    tick();
    checks++; if ({cf0[0], cs0[0]} !== 2'b01) begin errors++; $display("FAIL conf_kept got %b exp 01", {cf0[0], cs0[0]}); end
    clr0[0] = 1'b1;
    tick();
    clr0[0] = 1'b0;
  endtask

  task automatic test_restart();
    drive(0, 0, 1'b1, 4'h5);
    tick();
    drive(0, 0, 1'b0, 4'h0);
    tick();
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b0101_0000_1) begin errors++; $display("FAIL restart_hold5 got %b exp 010100001", {bv0[3:0], bu0[3:0], held0[0]}); end
    drive(0, 0, 1'b1, 4'h3);
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b0011_0000_0) begin errors++; $display("FAIL restart_drive3 got %b exp 001100000", {bv0[3:0], bu0[3:0], held0[0]}); end
    drive(0, 0, 1'b0, 4'h0);
    tick();
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b0011_0000_1) begin errors++; $display("FAIL restart_hold3 got %b exp 001100001", {bv0[3:0], bu0[3:0], held0[0]}); end
    tick();
    checks++; if ({bv0[3:0], bu0[3:0], held0[0]} !== 9'b0000_1111_0) begin errors++; $display("FAIL restart_decay got %b exp 000011110", {bv0[3:0], bu0[3:0], held0[0]}); end
  endtask

  task automatic test_pull_up_hold();
    int bad;
    bad = 0;
    en1 = 2'b01; val1 = 8'h06;
    tick();
    checks++; if ({bv1, bu1, held1} !== 9'b0110_0000_0) begin errors++; $display("FAIL pu_drive got %b exp 011000000", {bv1, bu1, held1}); end
    en1 = 2'b00; val1 = 8'h00;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({bv1, bu1, held1} !== 9'b0110_0000_1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pu_hold100 got %0d bad cycles exp 0", bad); end
    #2 rst1 = 1'b1;
    #1;
    checks++; if ({bv1, bu1, held1} !== 9'b1111_0000_0) begin errors++; $display("FAIL pu_async_rst got %b exp 111100000", {bv1, bu1, held1}); end
    tick();
    rst1 = 1'b0;
  endtask

  task automatic test_multi_channel();
    drive(0, 0, 1'b1, 4'h1);
    drive(1, 0, 1'b1, 4'h2);
    drive(1, 1, 1'b1, 4'h2);
    drive(2, 0, 1'b1, 4'h4);
    drive(2, 1, 1'b1, 4'h5);
    drive(3, 1, 1'b1, 4'h8);
    tick();
    checks++; if (bv0 !== 16'h8421) begin errors++; $display("FAIL multi_val got %h exp 8421", bv0); end
    checks++; if (bu0 !== 16'h0100) begin errors++; $display("FAIL multi_unk got %h exp 0100", bu0); end
    checks++; if ({cf0, cs0} !== 8'b0100_0100) begin errors++; $display("FAIL multi_conf got %b exp 01000100", {cf0, cs0}); end
    en0 = '0; val0 = '0;
    tick();
    checks++; if ({cf0, held0} !== 8'b0000_1111) begin errors++; $display("FAIL multi_after got %b exp 00001111", {cf0, held0}); end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    en0 = '0; val0 = '0; clr0 = '0;
    en1 = '0; val1 = '0; clr1 = '0;
    test_reset();
    test_hold_decay();
    test_conflict();
    test_restart();
    test_pull_up_hold();
    test_multi_channel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
